uart_tx_arbiter: RTL and testbench

// - Shares the single UART transmitter between N_REQ byte-stream requesters (result dump, memory dump, echo).
// - Round-robin grant per packet; grant held until requester's last byte (plus optional CR/LF suffix) has left the line.
// - Sits between the command-controller sources and the UART TX FSM; replaces direct start/busy wiring.

---
 rtl/uart_tx_arbiter_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Arbiter state literals carry an A_ prefix to stay clear of the RX/TX/controller FSM names.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    A_IDLE,
    A_SEND,
    A_WACK,
    A_WDONE,
    A_SUFX,
    A_REL
  } arb_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Index width that stays legal when there is only one requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_rr_ptr, wrapping.
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0]              i_req_valid,
  input  logic [idx_width(N_REQ)-1:0]   i_rr_ptr,
  output logic [N_REQ-1:0]              o_grant,
  output logic [idx_width(N_REQ)-1:0]   o_idx,
  output logic                          o_any
);

  localparam int unsigned IDX_W = idx_width(N_REQ);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [2*N_REQ-1:0] w_rot;
  logic [SUM_W-1:0]   w_sum;
  logic               w_found;

  // Rotating a doubled copy puts the search start at bit 0.
  assign w_rot = {i_req_valid, i_req_valid} >> i_rr_ptr;
  assign o_any = |i_req_valid;

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    o_idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, i_rr_ptr} + SUM_W'(j);
        if (w_sum >= SUM_W'(N_REQ)) begin
          w_sum = w_sum - SUM_W'(N_REQ);
        end
        o_idx = w_sum[IDX_W-1:0];
      end
    end
    o_grant = w_found ? (N_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter between N_REQ byte streams,
// with an optional CR/LF suffix per packet and a start-acknowledge timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned APPEND_CRLF = 1,
  parameter int unsigned ACK_TO      = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  input  logic [N_REQ-1:0]          i_req_last,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic [N_REQ-1:0]          o_grant,
  output logic [DATA_W-1:0]         o_tx_data,
  output logic                      o_tx_start,
  input  logic                      i_tx_busy,
  output logic                      o_arb_busy,
  output logic                      o_err_to
);

  localparam int unsigned IDX_W = idx_width(N_REQ);
  localparam int unsigned CNT_W = $clog2(ACK_TO);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TO - 1);

  arb_state_t        r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_grant, w_grant_nxt;
  logic [IDX_W-1:0]  r_grant_idx, w_grant_idx_nxt;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [DATA_W-1:0] r_tx_data, w_tx_data_nxt;
  logic              r_tx_start, w_tx_start_nxt;
  logic [N_REQ-1:0]  r_req_ready, w_req_ready_nxt;
  logic              r_err_to, w_err_to_nxt;
  logic              r_arb_busy;
  logic              r_last, w_last_nxt;
  logic [1:0]        r_sfx_idx, w_sfx_idx_nxt;
  logic [CNT_W-1:0]  r_to_cnt, w_to_cnt_nxt;

  logic [N_REQ-1:0]  w_pick_grant;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_data;

  uart_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .i_req_valid(i_req_valid),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_pick_grant),
    .o_idx      (w_pick_idx),
    .o_any      (w_pick_any)
  );

  // One-hot grant doubles as the select for the owner's request lines.
  assign w_sel_valid = |(i_req_valid & r_grant);
  assign w_sel_last  = |(i_req_last & r_grant);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sel_data = w_sel_data | (i_req_data[i*DATA_W +: DATA_W] & {DATA_W{r_grant[i]}});
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_tx_data_nxt   = r_tx_data;
    w_tx_start_nxt  = 1'b0;
    w_req_ready_nxt = '0;
    w_err_to_nxt    = 1'b0;
    w_last_nxt      = r_last;
    w_sfx_idx_nxt   = r_sfx_idx;
    w_to_cnt_nxt    = r_to_cnt;

    unique case (r_state)
      A_IDLE: begin
        w_last_nxt   = 1'b0;
        w_to_cnt_nxt = '0;
        if (w_pick_any) begin
          w_grant_nxt     = w_pick_grant;
          w_grant_idx_nxt = w_pick_idx;
          w_state_nxt     = A_SEND;
        end
      end
      A_SEND: begin
        // A busy line here is a frame we did not start; never stack a start on it.
        if (!i_tx_busy && w_sel_valid) begin
          w_tx_data_nxt   = w_sel_data;
          w_tx_start_nxt  = 1'b1;
          w_req_ready_nxt = r_grant;
          w_last_nxt      = w_sel_last;
          w_to_cnt_nxt    = '0;
          w_state_nxt     = A_WACK;
        end
      end
      A_WACK: begin
        if (i_tx_busy) begin
          w_to_cnt_nxt = '0;
          w_state_nxt  = A_WDONE;
        end else if (r_to_cnt == CNT_MAX) begin
          w_err_to_nxt = 1'b1;
          w_to_cnt_nxt = '0;
          w_state_nxt  = A_REL;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end
      A_WDONE: begin
        if (!i_tx_busy) begin
          if (!r_last) begin
            w_state_nxt = A_SEND;
          end else if (APPEND_CRLF != 0 && r_sfx_idx != 2'd2) begin
            w_state_nxt = A_SUFX;
          end else begin
            w_state_nxt = A_REL;
          end
        end
      end
      A_SUFX: begin
        if (!i_tx_busy) begin
          w_tx_data_nxt  = (r_sfx_idx == 2'd0) ? DATA_W'(ASCII_CR) : DATA_W'(ASCII_LF);
          w_tx_start_nxt = 1'b1;
          w_sfx_idx_nxt  = r_sfx_idx + 2'd1;
          w_to_cnt_nxt   = '0;
          w_state_nxt    = A_WACK;
        end
      end
      A_REL: begin
        w_grant_nxt   = '0;
        w_rr_ptr_nxt  = (r_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : r_grant_idx + 1'b1;
        w_sfx_idx_nxt = 2'd0;
        w_state_nxt   = A_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = A_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= A_IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_req_ready <= '0;
      r_err_to    <= 1'b0;
      r_arb_busy  <= 1'b0;
      r_last      <= 1'b0;
      r_sfx_idx   <= 2'd0;
      r_to_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_err_to    <= w_err_to_nxt;
      r_arb_busy  <= (w_state_nxt != A_IDLE);
      r_last      <= w_last_nxt;
      r_sfx_idx   <= w_sfx_idx_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
    end
  end

  assign o_grant     = r_grant;
  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_req_ready = r_req_ready;
  assign o_err_to    = r_err_to;
  assign o_arb_busy  = r_arb_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random multi-requester phases scored
// against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N = 3;

  typedef struct packed {
    logic [7:0]   data;
    logic [N-1:0] grant;
    logic         sfx;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           arb_busy;
  logic           err_to;

  logic model_busy;
  logic foreign_busy;
  logic stuck;
  logic rand_gaps;

  int n_checks;
  int n_errors;
  int n_starts;
  int n_ready;
  int n_stray;
  int n_err_to;
  int model_ptr;

  logic [8:0] req_q   [N][$];
  logic [8:0] stage_q [N][$];
  int         gap     [N];
  exp_t       exp_q   [$];

  assign tx_busy = model_busy | foreign_busy;

  uart_tx_arbiter #(
    .N_REQ      (N),
    .DATA_W     (8),
    .APPEND_CRLF(1),
    .ACK_TO     (16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(req_valid),
    .i_req_data (req_data),
    .i_req_last (req_last),
    .o_req_ready(req_ready),
    .o_grant    (grant),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .i_tx_busy  (tx_busy),
    .o_arb_busy (arb_busy),
    .o_err_to   (err_to)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input int owner, input logic sfx);
    exp_t e;
    e.data  = d;
    e.grant = N'(1 << owner);
    e.sfx   = sfx;
    exp_q.push_back(e);
  endtask

  // A packet owns the line until its suffix is out, then the pointer moves past the owner.
  task automatic model_phase();
    int rd [N];
    int ptr;
    int remaining;
    int w;
    logic [8:0] b;
    ptr = model_ptr;
    remaining = 0;
    for (int i = 0; i < N; i++) begin
      rd[i] = 0;
      remaining += stage_q[i].size();
    end
    while (remaining > 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && rd[(ptr + k) % N] < stage_q[(ptr + k) % N].size()) w = (ptr + k) % N;
      end
      do begin
        b = stage_q[w][rd[w]];
        rd[w]++;
        remaining--;
        push_exp(b[7:0], w, 1'b0);
      end while (!b[8]);
      push_exp(8'h0D, w, 1'b1);
      push_exp(8'h0A, w, 1'b1);
      ptr = (w + 1) % N;
    end
    model_ptr = ptr;
    for (int i = 0; i < N; i++) begin
      while (stage_q[i].size() > 0) req_q[i].push_back(stage_q[i].pop_front());
    end
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    int pend;
    cyc = 0;
    forever begin
      pend = exp_q.size();
      for (int i = 0; i < N; i++) pend += req_q[i].size();
      if ((pend == 0 && !arb_busy && !tx_busy) || cyc >= 4000) break;
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_drained"}, 32'(cyc < 4000), 1);
    check_eq({tag, "_grant_idle"}, 32'(grant), 0);
  endtask

  // Requester models: present queue heads, advance on req_ready, optional stalls mid-packet.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) gap[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && req_q[i].size() > 0) begin
          logic was_last;
          was_last = req_q[i][0][8];
          void'(req_q[i].pop_front());
          if (!was_last && req_q[i].size() > 0 && rand_gaps) gap[i] = $urandom_range(0, 15);
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
        req_valid[i] = (req_q[i].size() > 0) && (gap[i] == 0);
        req_data[i*8 +: 8] = (req_q[i].size() > 0) ? req_q[i][0][7:0] : 8'h00;
        req_last[i] = (req_q[i].size() > 0) ? req_q[i][0][8] : 1'b0;
      end
    end
  end

  // UART TX model: busy rises one cycle after the start pulse and lasts ten cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !stuck) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        n_starts++;
        check_eq("start_while_busy", 32'(tx_busy), 0);
        check_eq("start_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("tx_data", 32'(tx_data), 32'(e.data));
          check_eq("grant_at_start", 32'(grant), 32'(e.grant));
          check_eq("req_ready", 32'(req_ready), e.sfx ? 32'd0 : 32'(e.grant));
        end
        if (|req_ready) n_ready++;
      end else if (|req_ready) begin
        n_stray++;
      end
      if (err_to) n_err_to++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, r0, cnt;
    rst = 1'b1;
    foreign_busy = 1'b0;
    stuck = 1'b0;
    rand_gaps = 1'b0;
    n_checks = 0; n_errors = 0; n_starts = 0; n_ready = 0; n_stray = 0; n_err_to = 0;
    model_ptr = 0;
    #1;
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_tx_start", 32'(tx_start), 0);
    check_eq("rst_err_to", 32'(err_to), 0);
    check_eq("rst_arb_busy", 32'(arb_busy), 0);
    check_eq("rst_tx_data", 32'(tx_data), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // All three valid with one-byte packets, twice: order 0,1,2 then 0,1,2.
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        req_q[r].push_back({1'b1, 8'(8'hA0 + r)});
        push_exp(8'(8'hA0 + r), r, 1'b0);
        push_exp(8'h0D, r, 1'b1);
        push_exp(8'h0A, r, 1'b1);
      end
      wait_drain("rr");
    end

    // Req0 two-byte packet with suffix.
    @(negedge clk);
    s0 = n_starts;
    r0 = n_ready;
    req_q[0].push_back({1'b0, 8'h41});
    req_q[0].push_back({1'b1, 8'h42});
    push_exp(8'h41, 0, 1'b0);
    push_exp(8'h42, 0, 1'b0);
    push_exp(8'h0D, 0, 1'b1);
    push_exp(8'h0A, 0, 1'b1);
    wait_drain("pkt0");
    check_eq("pkt0_starts", 32'(n_starts - s0), 4);
    check_eq("pkt0_readies", 32'(n_ready - r0), 2);

    // Req0 arrives while req1 owns the line: must wait for req1's full packet and suffix.
    @(negedge clk);
    req_q[1].push_back({1'b0, 8'h10});
    req_q[1].push_back({1'b0, 8'h11});
    req_q[1].push_back({1'b1, 8'h12});
    push_exp(8'h10, 1, 1'b0);
    push_exp(8'h11, 1, 1'b0);
    push_exp(8'h12, 1, 1'b0);
    push_exp(8'h0D, 1, 1'b1);
    push_exp(8'h0A, 1, 1'b1);
    push_exp(8'h20, 0, 1'b0);
    push_exp(8'h0D, 0, 1'b1);
    push_exp(8'h0A, 0, 1'b1);
    cnt = 0;
    while (grant != 3'b010 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("lock_grant1", 32'(grant), 32'b010);
    req_q[0].push_back({1'b1, 8'h20});
    wait_drain("lock");

    // Foreign frame on the line when SEND is entered.
    @(negedge clk);
    foreign_busy = 1'b1;
    req_q[1].push_back({1'b1, 8'h55});
    push_exp(8'h55, 1, 1'b0);
    push_exp(8'h0D, 1, 1'b1);
    push_exp(8'h0A, 1, 1'b1);
    cnt = 0;
    while (grant != 3'b010 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("fb_grant1", 32'(grant), 32'b010);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (tx_start) cnt++;
    end
    check_eq("fb_no_start", 32'(cnt), 0);
    @(posedge clk);
    #1 foreign_busy = 1'b0;
    @(negedge clk);
    check_eq("fb_start_early", 32'(tx_start), 0);
    @(negedge clk);
    check_eq("fb_start_after", 32'(tx_start), 1);
    wait_drain("fb");
    model_ptr = 2;

    // Start never acknowledged: timeout, drop, next requester served.
    @(negedge clk);
    stuck = 1'b1;
    req_q[0].push_back({1'b1, 8'h33});
    push_exp(8'h33, 0, 1'b0);
    push_exp(8'h77, 2, 1'b0);
    push_exp(8'h0D, 2, 1'b1);
    push_exp(8'h0A, 2, 1'b1);
    cnt = 0;
    while (grant != 3'b001 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    req_q[2].push_back({1'b1, 8'h77});
    cnt = 0;
    while (!tx_start && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (err_to) break;
    end
    check_eq("to_latency", 32'(cnt), 16);
    stuck = 1'b0;
    @(negedge clk);
    check_eq("to_grant_released", 32'(grant), 0);
    @(negedge clk);
    check_eq("to_next_grant", 32'(grant), 32'b100);
    wait_drain("to");
    model_ptr = 0;

    // Random phases against the packet-level model.
    rand_gaps = 1'b1;
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 2) != 0) begin
          int npk;
          npk = $urandom_range(1, 2);
          for (int k = 0; k < npk; k++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
              stage_q[r].push_back({1'(b == len - 1), 8'($urandom_range(0, 255))});
            end
          end
        end
      end
      model_phase();
      wait_drain("rand");
    end
    rand_gaps = 1'b0;

    // Asynchronous reset while waiting for a frame to finish.
    @(negedge clk);
    req_q[2].push_back({1'b0, 8'h71});
    req_q[2].push_back({1'b0, 8'h72});
    req_q[2].push_back({1'b1, 8'h73});
    push_exp(8'h71, 2, 1'b0);
    cnt = 0;
    while (!tx_busy && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("rst_mid_busy_seen", 32'(tx_busy), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    for (int r = 0; r < N; r++) begin
      req_q[r].delete();
      gap[r] = 0;
    end
    req_valid = '0;
    #1;
    check_eq("arst_grant", 32'(grant), 0);
    check_eq("arst_tx_start", 32'(tx_start), 0);
    check_eq("arst_arb_busy", 32'(arb_busy), 0);
    check_eq("arst_req_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    stage_q[1].push_back({1'b1, 8'h61});
    stage_q[2].push_back({1'b1, 8'h62});
    model_phase();
    wait_drain("post_rst");

    check_eq("stray_ready", 32'(n_stray), 0);
    check_eq("err_to_count", 32'(n_err_to), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
